// File: rtl/sdp_pkg.sv
// Shared types and instruction-format constants for the simple_datapath sequencer.
package sdp_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned FLAG_W  = 4;

    // Instruction word field positions
    localparam int unsigned OP_HI   = 31;
    localparam int unsigned RS_LO   = 24;
    localparam int unsigned RT_LO   = 19;
    localparam int unsigned RD_LO   = 14;
    localparam int unsigned WB_BIT  = 13;
    localparam int unsigned RSVD_HI = 12;

    // Bit positions inside the packed {c,n,z,p} flag vector
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_P = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_INC = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SL  = 3'd6,
        OP_NOP = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAP  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;
        logic              err;
    } resp_t;

    function automatic logic rsvd_nonzero(input logic [DATA_W-1:0] word);
        return |word[RSVD_HI:0];
    endfunction

endpackage

// File: rtl/sdp_instr_decode.sv
// Combinational split of an instruction word into datapath controls plus
// the error and write-back qualification bits.
module sdp_instr_decode
    import sdp_pkg::*;
#(
    parameter int unsigned DW = sdp_pkg::DATA_W,
    parameter int unsigned AW = sdp_pkg::RADDR_W
) (
    input  logic [DW-1:0] instr_i,
    output op_e           op_c_o,
    output logic [AW-1:0] rs_c_o,
    output logic [AW-1:0] rt_c_o,
    output logic [AW-1:0] rd_c_o,
    output logic          err_c_o,
    output logic          wb_ok_c_o
);

    logic wb_c;

    assign op_c_o  = op_e'(instr_i[OP_HI -: OP_W]);
    assign rs_c_o  = instr_i[RS_LO +: AW];
    assign rt_c_o  = instr_i[RT_LO +: AW];
    assign rd_c_o  = instr_i[RD_LO +: AW];
    assign wb_c    = instr_i[WB_BIT];
    assign err_c_o = rsvd_nonzero(DATA_W'(instr_i));

    // r0 is hard-wired, nop produces nothing, and a malformed word never commits
    assign wb_ok_c_o = wb_c && (rd_c_o != '0) && (op_c_o != OP_NOP) && !err_c_o;

endmodule

// File: rtl/datapath_sequencer.sv
// Control stage in front of simple_datapath: accepts one instruction, runs
// it through EXEC/CAP, optionally writes back, and returns result and flags.
module datapath_sequencer
    import sdp_pkg::*;
#(
    parameter int unsigned DW   = sdp_pkg::DATA_W,
    parameter int unsigned AW   = sdp_pkg::RADDR_W,
    parameter int unsigned CW   = sdp_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DW-1:0]     instr,
    output logic [OP_W-1:0]   op_code,
    output logic [AW-1:0]     rs,
    output logic [AW-1:0]     rt,
    output logic [AW-1:0]     rd,
    output logic              wr_en,
    output logic [DW-1:0]     d_in,
    input  logic [DW-1:0]     d_out,
    input  logic              c,
    input  logic              n,
    input  logic              z,
    input  logic              p,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DW-1:0]     result,
    output logic [FLAG_W-1:0] flags,
    output logic              err,
    output logic              busy,
    output logic [CW-1:0]     retired_cnt
);

    state_e              state_q, state_d;
    logic [DW-1:0]       instr_q, instr_d;
    logic [DW-1:0]       dec_word_c;
    op_e                 dec_op_c;
    logic [AW-1:0]       dec_rs_c, dec_rt_c, dec_rd_c;
    logic                dec_err_c, dec_wb_ok_c;
    logic                accept_c, resp_done_c;

    logic [OP_W-1:0]     op_code_q, op_code_d;
    logic [AW-1:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic                wr_en_q, wr_en_d;
    logic                instr_ready_q, instr_ready_d;
    logic                busy_q, busy_d;
    logic                resp_valid_q, resp_valid_d;
    resp_t               resp_q, resp_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    assign accept_c    = (state_q == ST_IDLE) && instr_valid;
    assign resp_done_c = (state_q == ST_RESP) && resp_ready;

    // Decode the incoming word while idle so controls are registered into EXEC
    assign dec_word_c = (state_q == ST_IDLE) ? instr : instr_q;

    sdp_instr_decode #(
        .DW (DW),
        .AW (AW)
    ) u_decode (
        .instr_i   (dec_word_c),
        .op_c_o    (dec_op_c),
        .rs_c_o    (dec_rs_c),
        .rt_c_o    (dec_rt_c),
        .rd_c_o    (dec_rd_c),
        .err_c_o   (dec_err_c),
        .wb_ok_c_o (dec_wb_ok_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_CAP;
            ST_CAP:  state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, keyed on the upcoming state
    always_comb begin
        instr_d       = instr_q;
        op_code_d     = OP_NOP;
        rs_d          = rs_q;
        rt_d          = rt_q;
        rd_d          = rd_q;
        wr_en_d       = 1'b0;
        instr_ready_d = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        resp_valid_d  = (state_d == ST_RESP);
        resp_d        = resp_q;
        cnt_d         = cnt_q;

        if (accept_c) begin
            instr_d    = instr;
            rs_d       = dec_rs_c;
            rt_d       = dec_rt_c;
            rd_d       = dec_rd_c;
            resp_d.err = dec_err_c;
        end
        if ((state_d == ST_EXEC) || (state_d == ST_CAP)) begin
            op_code_d = dec_op_c;
        end
        if (state_d == ST_CAP) begin
            wr_en_d = dec_wb_ok_c;
        end
        if (state_q == ST_CAP) begin
            resp_d.result = d_out;
            resp_d.flags  = {c, n, z, p};
        end
        if (resp_done_c) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Registered outputs and datapath context
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q       <= '0;
            op_code_q     <= OP_NOP;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            wr_en_q       <= 1'b0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_q        <= '0;
            cnt_q         <= '0;
        end else begin
            instr_q       <= instr_d;
            op_code_q     <= op_code_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            wr_en_q       <= wr_en_d;
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
            resp_valid_q  <= resp_valid_d;
            resp_q        <= resp_d;
            cnt_q         <= cnt_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign op_code     = op_code_q;
    assign rs          = rs_q;
    assign rt          = rt_q;
    assign rd          = rd_q;
    assign busy        = busy_q;
    assign resp_valid  = resp_valid_q;
    assign result      = resp_q.result;
    assign flags       = resp_q.flags;
    assign err         = resp_q.err;
    assign retired_cnt = cnt_q;

    // Reset in the write cycle must kill the strobe before the datapath edge sees it
    assign wr_en = wr_en_q && !reset;
    assign d_in  = (state_q == ST_CAP) ? d_out : '0;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer with a behavioural simple_datapath around it
// and a reference register-file/response model.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [2:0]  op_code;
    logic [4:0]  rs, rt, rd;
    logic        wr_en;
    logic [31:0] d_in, d_out;
    logic        c, n, z, p;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        err, busy;
    logic [15:0] retired_cnt;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    logic        rf_load = 1'b1;
    logic [31:0] init_rf [32];
    logic [31:0] ref_rf  [32];
    logic [31:0] rf      [32];
    logic [31:0] dp_q;
    logic [3:0]  fl_q;
    int          wr_pulses;

    always #5 clk = ~clk;

    datapath_sequencer dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .op_code(op_code), .rs(rs), .rt(rt), .rd(rd), .wr_en(wr_en),
        .d_in(d_in), .d_out(d_out), .c(c), .n(n), .z(z), .p(p),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result), .flags(flags),
        .err(err), .busy(busy), .retired_cnt(retired_cnt)
    );

    // {flags[3:0] = c,n,z,p ; result[31:0]}
    function automatic logic [35:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        case (op)
            3'd0:    w = {1'b0, a} + {1'b0, b};
            3'd1:    w = {1'b0, a} + 33'd1;
            3'd2:    w = {1'b0, a & b};
            3'd3:    w = {1'b0, a | b};
            3'd4:    w = {1'b0, a ^ b};
            3'd5:    w = {1'b0, ~a};
            3'd6:    w = {a, 1'b0};
            default: w = '0;
        endcase
        r = w[31:0];
        return {w[32], r[31], (r == 32'd0), (!r[31] && (r != 32'd0)), r};
    endfunction

    // Behavioural simple_datapath: registered ALU output, synchronous register write
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_rf[i];
            wr_pulses <= 0;
        end else if (wr_en) begin
            rf[rd]    <= d_in;
            wr_pulses <= wr_pulses + 1;
        end
        {fl_q, dp_q} <= alu(op_code, rf[rs], rf[rt]);
    end

    assign d_out = dp_q;
    assign {c, n, z, p} = fl_q;

    function automatic logic [31:0] mk(input int op, input int s, input int t, input int d,
                                       input int wb, input int rsvd);
        return 32'(op * (2 ** 29) + s * (2 ** 24) + t * (2 ** 19) + d * (2 ** 14) + wb * (2 ** 13) + rsvd);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold = RESP cycles with resp_ready low, early = ready before RESP
    task automatic run_instr(input logic [31:0] w, input int hold, input bit early);
        int          op, s, t, d, wb;
        bit          bad, will_wr;
        logic [35:0] e;
        int          pulses0;
        op  = int'(w / (2 ** 29));
        s   = int'((w / (2 ** 24)) % 32);
        t   = int'((w / (2 ** 19)) % 32);
        d   = int'((w / (2 ** 14)) % 32);
        wb  = int'((w / (2 ** 13)) % 2);
        bad = (w % 8192) != 0;
        will_wr = (wb == 1) && (d != 0) && (op != 7) && !bad;
        e = alu(3'(op), ref_rf[s], ref_rf[t]);

        @(negedge clk);
        chk("ready_idle", 32'(instr_ready), 32'd1);
        pulses0 = wr_pulses;
        instr = w;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = $urandom;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_ready", 32'(instr_ready), 32'd0);
        chk("exec_op", 32'(op_code), 32'(op));
        chk("exec_regs", {17'd0, rs, rt, rd}, 32'(s * 1024 + t * 32 + d));
        if (early) resp_ready = 1'b1;
        @(negedge clk);
        chk("cap_wr_en", 32'(wr_en), 32'(will_wr));
        chk("cap_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("result", result, e[31:0]);
        chk("flags", 32'(flags), 32'(e[35:32]));
        chk("err", 32'(err), 32'(bad));
        for (int k = 0; k < hold; k++) begin
            instr_valid = 1'b1;
            instr = $urandom;
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_result", result, e[31:0]);
            chk("hold_ready", 32'(instr_ready), 32'd0);
        end
        instr_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 65536;
        if (will_wr) ref_rf[d] = e[31:0];
        chk("done_valid", 32'(resp_valid), 32'd0);
        chk("done_idle", {30'd0, instr_ready, busy}, 32'd2);
        chk("done_op_nop", 32'(op_code), 32'd7);
        chk("retired_cnt", 32'(retired_cnt), 32'(exp_cnt));
        chk("wr_pulses", 32'(wr_pulses - pulses0), 32'(will_wr));
        chk("rf_target", rf[d], ref_rf[d]);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) init_rf[i] = 32'd0;
        init_rf[1] = 32'hFFFF0000;
        init_rf[2] = 32'h0A0A0A0A;
        init_rf[3] = 32'h00000500;
        init_rf[4] = 32'h00001000;
        for (int i = 8; i < 32; i++) init_rf[i] = $urandom;
        for (int i = 0; i < 32; i++) ref_rf[i] = init_rf[i];

        // Reset for two cycles
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rf_load = 1'b0;
        chk("rst_op", 32'(op_code), 32'd7);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(retired_cnt), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_result", result, 32'd0);

        // Directed instructions
        run_instr(mk(0, 3, 4, 5, 1, 0), 0, 1'b0);
        chk("rf5_sum", rf[5], 32'h00001500);
        run_instr(mk(2, 1, 2, 9, 0, 0), 0, 1'b1);
        run_instr(mk(4, 2, 1, 10, 0, 0), 0, 1'b0);
        run_instr(mk(6, 4, 0, 0, 1, 0), 0, 1'b0);
        run_instr(mk(7, 1, 2, 6, 1, 0), 0, 1'b0);
        run_instr(mk(3, 1, 2, 8, 1, 0), 5, 1'b0);
        run_instr(mk(1, 3, 0, 11, 1, 1), 0, 1'b0);
        run_instr(mk(5, 2, 0, 12, 1, 0), 2, 1'b0);

        // Reset during the write-back cycle
        @(negedge clk);
        instr = mk(0, 3, 4, 7, 1, 0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        begin
            int pulses0;
            pulses0 = wr_pulses;
            @(negedge clk);
            reset = 1'b0;
            exp_cnt = 0;
            chk("abort_idle", {30'd0, instr_ready, busy}, 32'd2);
            chk("abort_valid", 32'(resp_valid), 32'd0);
            chk("abort_op", 32'(op_code), 32'd7);
            chk("abort_cnt", 32'(retired_cnt), 32'd0);
            chk("abort_rf7", rf[7], ref_rf[7]);
            chk("abort_pulses", 32'(wr_pulses - pulses0), 32'd0);
        end

        // Randomized instructions against the reference model
        for (int k = 0; k < 40; k++) begin
            int hold;
            bit early;
            int rsvd;
            rsvd  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8191)) : 0;
            hold  = int'($urandom_range(0, 3));
            early = (hold == 0) && ($urandom_range(0, 1) == 1);
            run_instr(mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 1)), rsvd), hold, early);
        end
        for (int i = 0; i < 32; i++) chk("rf_final", rf[i], ref_rf[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
